// File: rtl/cpu_datapath.sv
// Bus-oriented 8-bit CPU datapath: A/B/IR/OUT/MAR/PC registers, ALU, 16x8 RAM
// and a priority-encoded shared bus, with sticky halt and program-load port.
module cpu_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] ctrl,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [7:0]  insn,
  output logic [7:0]  bus,
  output logic [3:0]  pc,
  output logic [7:0]  out_val,
  output logic        halted,
  output logic        bus_err
);

  logic hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j;
  assign {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j} = ctrl;

  logic [7:0] a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d;
  logic [3:0] mar_q, mar_d, pc_q, pc_d;
  logic       halted_q, halted_d;
  logic [7:0] ram [16];
  logic [7:0] alu;
  logic       ram_we;

  assign alu = sub ? (a_q - b_q) : (a_q + b_q);

  always_comb begin
    bus = 8'h00;
    if (co)        bus = {4'b0, pc_q};
    else if (ro)   bus = ram[mar_q];
    else if (io)   bus = {4'b0, ir_q[3:0]};
    else if (ao)   bus = a_q;
    else if (sumo) bus = alu;
  end

  assign bus_err = (co & (ro | io | ao | sumo)) | (ro & (io | ao | sumo)) |
                   (io & (ao | sumo)) | (ao & sumo);

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    ir_d     = ir_q;
    out_d    = out_q;
    mar_d    = mar_q;
    pc_d     = pc_q;
    halted_d = halted_q | hlt;
    if (!halted_q) begin
      if (ai) a_d   = bus;
      if (bi) b_d   = bus;
      if (ii) ir_d  = bus;
      if (oi) out_d = bus;
      if (mi) mar_d = bus[3:0];
      if (j)       pc_d = bus[3:0];
      else if (ce) pc_d = pc_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      ir_q     <= 8'h00;
      out_q    <= 8'h00;
      mar_q    <= 4'h0;
      pc_q     <= 4'h0;
      halted_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      ir_q     <= ir_d;
      out_q    <= out_d;
      mar_q    <= mar_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // RAM keeps its contents through reset, so ctrl-driven writes are blocked while rst_n is low.
  assign ram_we = ri & ~halted_q & rst_n;

  // The program-load write is issued last so it wins an address collision with ri.
  always_ff @(posedge clk) begin
    if (ram_we)  ram[mar_q]     <= bus;
    if (prog_we) ram[prog_addr] <= prog_data;
  end

  assign insn    = ir_q;
  assign pc      = pc_q;
  assign out_val = out_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath: reset, program execution, wrap cases,
// simultaneous events and halt behaviour.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] ctrl_r;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  insn, bus, out_val;
  logic [3:0]  pc;
  logic        halted, bus_err;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] HLT = 15'h4000, MI = 15'h2000, RI = 15'h1000, RO = 15'h0800,
                          IO = 15'h0400, II = 15'h0200, AI = 15'h0100, AO = 15'h0080,
                          SUMO = 15'h0040, SUB = 15'h0020, BI = 15'h0010, OI = 15'h0008,
                          CE = 15'h0004, CO = 15'h0002, J = 15'h0001;

  cpu_datapath dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl_r), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .insn(insn), .bus(bus), .pc(pc), .out_val(out_val),
    .halted(halted), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [14:0] c);
    ctrl_r = c;
    @(posedge clk);
    #1;
    ctrl_r = '0;
  endtask

  task automatic poke(input logic [3:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    ctrl_r    = '0;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    poke(4'h0, 8'hA5);
    step(CE);
    step(CE);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 4'h0) begin errors++; $display("FAIL reset_async pc got %h exp 0", pc); end
    for (int i = 0; i < 3; i++) begin
      ctrl_r = 15'($urandom);
      @(posedge clk);
      #1;
    end
    ctrl_r = '0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (pc !== 4'h0 || insn !== 8'h00 || out_val !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc %h insn %h out %h halted %b exp 0 00 00 0", pc, insn, out_val, halted);
    end
    ctrl_r = RO;
    #1;
    checks++;
    if (bus !== 8'hA5) begin errors++; $display("FAIL reset_ram got %h exp a5", bus); end
    ctrl_r = AO;
    #1;
    checks++;
    if (bus !== 8'h00) begin errors++; $display("FAIL reset_a got %h exp 00", bus); end
    ctrl_r = '0;
    $display("test_reset done");
  endtask

  task automatic test_program();
    do_reset();
    poke(4'h0, 8'h1E);
    poke(4'h1, 8'h2F);
    poke(4'h2, 8'hE0);
    poke(4'hE, 8'h1C);
    poke(4'hF, 8'h0E);
    step(CO | MI);  step(RO | II | CE);  step(IO | MI);  step(RO | AI);
    step(CO | MI);  step(RO | II | CE);  step(IO | MI);  step(RO | BI);
    ctrl_r = SUMO;
    #1;
    checks++;
    if (bus !== 8'h2A) begin errors++; $display("FAIL prog_sum_bus got %h exp 2a", bus); end
    step(SUMO | AI);
    step(CO | MI);  step(RO | II | CE);  step(AO | OI);
    ctrl_r = AO;
    #1;
    checks++;
    if (bus !== 8'h2A) begin errors++; $display("FAIL prog_a got %h exp 2a", bus); end
    ctrl_r = '0;
    checks++;
    if (out_val !== 8'h2A) begin errors++; $display("FAIL prog_out got %h exp 2a", out_val); end
    checks++;
    if (pc !== 4'h3) begin errors++; $display("FAIL prog_pc got %h exp 3", pc); end
    checks++;
    if (insn !== 8'hE0) begin errors++; $display("FAIL prog_insn got %h exp e0", insn); end
    $display("test_program done");
  endtask

  task automatic test_wrap();
    do_reset();
    poke(4'h0, 8'hFF);  step(RO | AI);
    poke(4'h0, 8'h01);  step(RO | BI);
    step(SUMO | AI);
    ctrl_r = AO;
    #1;
    checks++;
    if (bus !== 8'h00) begin errors++; $display("FAIL wrap_add got %h exp 00", bus); end
    step(SUMO | SUB | AI);
    ctrl_r = AO;
    #1;
    checks++;
    if (bus !== 8'hFF) begin errors++; $display("FAIL wrap_sub got %h exp ff", bus); end
    ctrl_r = '0;
    do_reset();
    for (int i = 0; i < 15; i++) step(CE);
    checks++;
    if (pc !== 4'hF) begin errors++; $display("FAIL pc_count got %h exp f", pc); end
    step(CE);
    checks++;
    if (pc !== 4'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", pc); end
    $display("test_wrap done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    poke(4'h0, 8'h55);  step(RO | AI);
    poke(4'h0, 8'h07);  step(RO | J | CE);
    checks++;
    if (pc !== 4'h7) begin errors++; $display("FAIL j_ce got %h exp 7", pc); end
    ctrl_r = CO | AO;
    #1;
    checks++;
    if (bus !== 8'h07 || bus_err !== 1'b1) begin
      errors++; $display("FAIL co_ao bus %h err %b exp 07 1", bus, bus_err);
    end
    ctrl_r = AO;
    #1;
    checks++;
    if (bus !== 8'h55 || bus_err !== 1'b0) begin
      errors++; $display("FAIL ao_only bus %h err %b exp 55 0", bus, bus_err);
    end
    ctrl_r = '0;
    prog_we = 1'b1;  prog_addr = 4'h0;  prog_data = 8'h99;
    step(AO | RI);
    prog_we = 1'b0;
    ctrl_r = RO;
    #1;
    checks++;
    if (bus !== 8'h99) begin errors++; $display("FAIL prog_vs_ri got %h exp 99", bus); end
    prog_we = 1'b1;  prog_addr = 4'h3;  prog_data = 8'h3C;
    step(AO | RI);
    prog_we = 1'b0;
    ctrl_r = RO;
    #1;
    checks++;
    if (bus !== 8'h55) begin errors++; $display("FAIL ri_diff_addr got %h exp 55", bus); end
    ctrl_r = '0;
    $display("test_simultaneous done");
  endtask

  task automatic test_halt();
    do_reset();
    poke(4'h0, 8'h11);  step(RO | AI);
    step(HLT);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b exp 1", halted); end
    for (int i = 0; i < 3; i++) step(AI | CE | RI | CO);
    checks++;
    if (pc !== 4'h0) begin errors++; $display("FAIL halt_pc got %h exp 0", pc); end
    ctrl_r = AO;
    #1;
    checks++;
    if (bus !== 8'h11) begin errors++; $display("FAIL halt_a got %h exp 11", bus); end
    ctrl_r = RO;
    #1;
    checks++;
    if (bus !== 8'h11) begin errors++; $display("FAIL halt_ram got %h exp 11", bus); end
    ctrl_r = '0;
    poke(4'h0, 8'h77);
    ctrl_r = RO;
    #1;
    checks++;
    if (bus !== 8'h77 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_progwe bus %h halted %b exp 77 1", bus, halted);
    end
    ctrl_r = '0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %b exp 0", halted); end
    rst_n = 1'b1;
    step(CE);
    checks++;
    if (pc !== 4'h1) begin errors++; $display("FAIL post_halt_run got %h exp 1", pc); end
    $display("test_halt done");
  endtask

  initial begin
    rst_n     = 1'b0;
    ctrl_r    = '0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_program();
    test_wrap();
    test_simultaneous();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  system clock; all state updates on the rising edge. The control decoder updates on the falling edge, so controls are stable here.
- rst_n  input  1  asynchronous, active-low reset.
- ctrl  input  15  control word from the decoder.
- prog_we  input  1  program-load write strobe into RAM.
- prog_addr  input  4  program-load RAM address.
- prog_data  input  8  program-load RAM data.
- insn  output  8  instruction register contents; feeds the decoder.
- bus  output  8  current internal bus value (combinational).
- pc  output  4  program counter.
- out_val  output  8  output (display) register.
- halted  output  1  sticky halt flag.
- bus_err  output  1  more than one bus driver asserted this cycle (combinational).

REQ-002 ctrl bit map SHALL be:
- [14]=hlt, [13]=mi, [12]=ri, [11]=ro, [10]=io, [9]=ii, [8]=ai, [7]=ao
- [6]=sumo, [5]=sub, [4]=bi, [3]=oi, [2]=ce, [1]=co, [0]=j

Function
REQ-003 Internal state SHALL be:
- A, B, IR, OUT: 8-bit registers
- MAR: 4-bit register
- PC: 4-bit register
- RAM: 16x8 array
- halted: 1-bit flag

REQ-004 Bus source SHALL be selected by fixed priority co > ro > io > ao > sumo.
- co drives {4'b0,PC}.
- ro drives RAM[MAR].
- io drives {4'b0,IR[3:0]}.
- ao drives A.
- sumo drives the ALU result.
- With no driver asserted, the bus is 8'h00.

REQ-005 bus_err SHALL be 1 whenever two or more of co/ro/io/ao/sumo are asserted; it is combinational and does not alter state.

REQ-006 ALU result SHALL be A+B when sub=0 and A-B (two's complement) when sub=1, truncated to 8 bits with wrap-around (e.g., 8'hFF+8'h01=8'h00; 8'h00-8'h01=8'hFF).

REQ-007 On each rising clk edge with halted=0, the following loads SHALL take the bus value, all within the same edge:
- ai loads A; bi loads B; oi loads OUT; ii loads IR.
- mi loads MAR (bus[3:0]); ri writes RAM[MAR].
- j loads PC (bus[3:0]).

REQ-008 Register loads SHALL sample pre-edge values, so ai with sumo in the same cycle loads the sum of the old A and B.

REQ-009 ce SHALL increment PC modulo 16 (4'hF wraps to 4'h0); if j and ce are both asserted, j wins.

REQ-010 ri with ro in the same cycle SHALL write back the unchanged RAM[MAR]; ri writes the pre-edge MAR even if mi is also asserted.

REQ-011 hlt SHALL set halted on the next rising edge; halted stays 1 until reset.

REQ-012 While halted=1, all ctrl-driven updates (A, B, IR, OUT, MAR, PC, RAM via ri) SHALL be suppressed; bus and bus_err remain combinational.

REQ-013 prog_we SHALL write prog_data to RAM[prog_addr] on the rising edge regardless of halted.
- If ri targets the same address in the same cycle, prog_we wins.
- If the addresses differ, both writes occur.

REQ-014 RAM reads SHALL be asynchronous (combinational from MAR).

Reset
REQ-015 While rst_n=0, the block SHALL immediately force A, B, IR, OUT, MAR, PC to 0 and halted to 0, independent of clk, including mid-instruction.

REQ-016 RAM contents SHALL be unaffected by reset; the first rising edge after rst_n rises behaves normally.

Verification
REQ-017 Reset: drive ctrl with random values while reset is active, then release -> pc=0, insn=0, out_val=0, halted=0; previously loaded RAM data intact.

REQ-018 LDA/ADD/OUT program: preload RAM[0]=8'h1E, RAM[1]=8'h2F, RAM[2]=8'hE0, RAM[14]=8'h1C, RAM[15]=8'h0E, then apply fetch/execute control words per cycle -> A=8'h2A after ADD, out_val=8'h2A, pc=3.

REQ-019 Wrap cases:
- A=8'hFF, B=8'h01, sumo+ai -> A=8'h00.
- sub with A=0, B=1 -> A=8'hFF.
- PC=4'hF with ce -> 4'h0.

REQ-020 Simultaneous events:
- j+ce with bus=8'h07 -> pc=7.
- co+ao asserted together -> bus=PC, bus_err=1.
- prog_we and ri to the same address -> prog_data stored.

REQ-021 Halt: assert hlt, then ai/ce/ri for 3 cycles -> halted=1, A/PC/RAM unchanged; prog_we still writes; async reset pulse clears halted.
